tone_loader: RTL and testbench



---
 rtl/tone_loader.sv | 122 ++++++++++++
 tb/tb_tone_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_loader.sv
// Byte-stream loader for the tone table RAM: assembles little-endian words into
// (note, phase) pairs from address 0 and always finishes on a zero-note terminator.
`timescale 1ns/1ps
module tone_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned TIMEOUT   = 48000
) (
    input  logic              clk48m,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-2:0] load_count
);

    localparam int unsigned       TW        = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_NOTE = ADDR_W'((1 << ADDR_W) - 2);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, ABORT} state_t;

    state_t            r_state;
    logic [31:0]       r_word;
    logic [1:0]        r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic [TW-1:0]     r_tmo;

    logic              w_accept;
    logic [31:0]       w_word;
    logic              w_overflow;

    assign in_ready = (r_state == IDLE) || (r_state == RECV);
    assign w_accept = in_valid && in_ready;
    assign w_word   = {in_data, r_word[23:0]};
    // The overflow substitution must be decided on the fourth byte so the data is registered with ram_we.
    assign w_overflow = !r_addr[0] && (w_word[26:0] != 27'd0) && (r_addr == LAST_NOTE);

    always_ff @(posedge clk48m or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_idx      <= '0;
            r_addr     <= '0;
            r_tmo      <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            load_count <= '0;
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && in_data == SYNC_BYTE) begin
                        r_state    <= RECV;
                        r_idx      <= '0;
                        r_addr     <= '0;
                        r_tmo      <= '0;
                        load_count <= '0;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                RECV: begin
                    if (w_accept) begin
                        r_tmo                <= '0;
                        r_word[8*r_idx +: 8] <= in_data;
                        r_idx                <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state   <= WRITE;
                            ram_we    <= 1'b1;
                            ram_addr  <= r_addr;
                            ram_wdata <= w_overflow ? 32'h0 : w_word;
                        end
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        r_state   <= ABORT;
                        ram_we    <= 1'b1;
                        ram_addr  <= '0;
                        ram_wdata <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                WRITE: begin
                    r_tmo <= '0;
                    if (r_addr[0]) begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= RECV;
                    end else if (r_word[26:0] == 27'd0) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (r_addr == LAST_NOTE) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        error   <= 1'b1;
                    end else begin
                        load_count <= load_count + 1'b1;
                        r_addr     <= r_addr + 1'b1;
                        r_state    <= RECV;
                    end
                end
                ABORT: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    error   <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_loader.sv
// Randomized bench for tone_loader: two instances (full depth and an 8-word table)
// compared against a frame-level model of what the loader must write.
`timescale 1ns/1ps
module tb_tone_loader;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int TMO = 40;

    logic        clk48m = 1'b0;
    logic        rst_n  = 1'b0;

    logic [7:0]  a_data = '0;
    logic        a_valid = 1'b0;
    logic        a_ready, a_we, a_busy, a_done, a_err;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata;
    logic [8:0]  a_cnt;

    logic [7:0]  b_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready, b_we, b_busy, b_done, b_err;
    logic [2:0]  b_addr;
    logic [31:0] b_wdata;
    logic [1:0]  b_cnt;

    tone_loader #(.SYNC_BYTE(SYNC), .ADDR_W(10), .TIMEOUT(TMO)) dut_a (
        .clk48m(clk48m), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .ram_we(a_we), .ram_addr(a_addr), .ram_wdata(a_wdata),
        .busy(a_busy), .done(a_done), .error(a_err), .load_count(a_cnt)
    );

    tone_loader #(.SYNC_BYTE(SYNC), .ADDR_W(3), .TIMEOUT(TMO)) dut_b (
        .clk48m(clk48m), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .ram_we(b_we), .ram_addr(b_addr), .ram_wdata(b_wdata),
        .busy(b_busy), .done(b_done), .error(b_err), .load_count(b_cnt)
    );

    always #10 clk48m = ~clk48m;

    int unsigned cyc = 0;
    always @(posedge clk48m) cyc <= cyc + 1;

    logic [63:0] obs_a[$];
    logic [63:0] obs_b[$];
    int done_n[2], gap[2], busy_hi[2], stalls[2];
    int unsigned we_cyc[2];

    always @(negedge clk48m) begin
        if (a_we) begin obs_a.push_back({32'(a_addr), a_wdata}); we_cyc[0] = cyc; end
        if (b_we) begin obs_b.push_back({32'(b_addr), b_wdata}); we_cyc[1] = cyc; end
        if (a_done) begin done_n[0]++; gap[0] = int'(cyc - we_cyc[0]); if (a_busy) busy_hi[0]++; end
        if (b_done) begin done_n[1]++; gap[1] = int'(cyc - we_cyc[1]); if (b_busy) busy_hi[1]++; end
        if (a_valid && !a_ready) stalls[0]++;
        if (b_valid && !b_ready) stalls[1]++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: walks the byte list and lists the writes the loader must make.
    logic [63:0] exp_w[$];
    int          exp_cnt;
    bit          exp_err, exp_done;

    task automatic model(input logic [7:0] q[$], input int depth);
        int i = 0;
        int addr = 0;
        bit fin = 0;
        logic [31:0] w;
        exp_w.delete();
        exp_cnt = 0; exp_err = 0; exp_done = 0;
        while (i < q.size() && q[i] != SYNC) i++;
        i++;
        while (!fin && i + 4 <= q.size()) begin
            w = {q[i+3], q[i+2], q[i+1], q[i]};
            i += 4;
            if (addr % 2 == 1) begin
                exp_w.push_back({32'(addr), w}); addr++;
            end else if (w[26:0] == 27'd0) begin
                exp_w.push_back({32'(addr), w}); exp_done = 1; fin = 1;
            end else if (addr == depth - 2) begin
                exp_w.push_back({32'(addr), 32'h0}); exp_err = 1; fin = 1;
            end else begin
                exp_w.push_back({32'(addr), w}); exp_cnt++; addr++;
            end
        end
    endtask

    logic [7:0] frm[$];
    int unsigned acc_cyc;

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) frm.push_back(w[8*k +: 8]);
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        int n = 0;
        bit acc = 0;
        if (sel) begin b_data = b; b_valid = 1'b1; end
        else     begin a_data = b; a_valid = 1'b1; end
        while (!acc && n < 200) begin
            acc = sel ? b_ready : a_ready;
            @(posedge clk48m); #1;
            n++;
        end
        acc_cyc = cyc;
        if (!acc) check("accept_bound", 64'(acc), 64'd1);
    endtask

    task automatic idle(input bit sel, input int n);
        if (sel) b_valid = 1'b0; else a_valid = 1'b0;
        repeat (n) @(posedge clk48m);
        #1;
    endtask

    task automatic clear_mon();
        obs_a.delete(); obs_b.delete();
        for (int s = 0; s < 2; s++) begin
            done_n[s] = 0; gap[s] = 0; busy_hi[s] = 0; stalls[s] = 0;
        end
    endtask

    task automatic run_load(input string tag, input bit sel, input bit gaps);
        logic [63:0] obs[$];
        int n = 0;
        int nmin;
        clear_mon();
        foreach (frm[k]) begin
            send(sel, frm[k]);
            if (gaps && $urandom_range(0, 2) == 0) idle(sel, int'($urandom_range(1, 5)));
        end
        if (sel) b_valid = 1'b0; else a_valid = 1'b0;
        while ((sel ? b_busy : a_busy) && n < 20) begin @(posedge clk48m); #1; n++; end
        idle(sel, 3);
        model(frm, sel ? 8 : 1024);
        obs = sel ? obs_b : obs_a;
        check({tag, "_nwrites"}, 64'(obs.size()), 64'(exp_w.size()));
        nmin = (obs.size() < exp_w.size()) ? obs.size() : exp_w.size();
        for (int k = 0; k < nmin; k++) check($sformatf("%s_w%0d", tag, k), obs[k], exp_w[k]);
        check({tag, "_count"}, sel ? 64'(b_cnt) : 64'(a_cnt), 64'(exp_cnt));
        check({tag, "_error"}, sel ? 64'(b_err) : 64'(a_err), 64'(exp_err));
        check({tag, "_done"}, 64'(done_n[sel]), 64'(exp_done));
        if (exp_done) begin
            check({tag, "_done_gap"}, 64'(gap[sel]), 64'd1);
            check({tag, "_busy_at_done"}, 64'(busy_hi[sel]), 64'd0);
        end
    endtask

    task automatic case1_frame();
        frm.push_back(SYNC);
        push_word(32'h0000_0010);
        push_word(32'h0000_0140);
        push_word(32'h0000_0000);
    endtask

    initial begin
        int n;
        logic [31:0] w;
        logic [7:0]  jb;
        bit sel;

        repeat (3) @(posedge clk48m);
        #1;
        check("rst_ready", 64'(a_ready), 64'd1);
        check("rst_we", 64'(a_we), 64'd0);
        check("rst_addr_data", {32'(a_addr), a_wdata}, 64'd0);
        check("rst_flags", {61'd0, a_busy, a_done, a_err}, 64'd0);
        check("rst_count", 64'(a_cnt), 64'd0);
        @(negedge clk48m) rst_n = 1'b1;
        @(posedge clk48m); #1;

        frm.delete(); case1_frame();
        run_load("c1", 0, 0);
        check("c1_stalls", 64'(stalls[0]), 64'd2);
        check("c1_w0_const", obs_a.size() > 0 ? obs_a[0] : 64'hX, {32'd0, 32'h10});

        frm.delete(); frm.push_back(8'h00); frm.push_back(8'hFF); frm.push_back(8'h12); case1_frame();
        run_load("c2", 0, 1);

        frm.delete(); frm.push_back(SYNC); push_word(32'hF800_0000);
        run_load("c3", 0, 0);

        clear_mon();
        send(0, SYNC); send(0, 8'h11); send(0, 8'h22);
        a_valid = 1'b0;
        n = 0;
        while (obs_a.size() == 0 && n < TMO + 20) begin @(posedge clk48m); #1; n++; end
        check("tmo_nwrites", 64'(obs_a.size()), 64'd1);
        if (obs_a.size() > 0) begin
            check("tmo_w0", obs_a[0], 64'd0);
            check("tmo_delay", 64'(we_cyc[0] - acc_cyc), 64'(TMO));
        end
        idle(0, 3);
        check("tmo_error", 64'(a_err), 64'd1);
        check("tmo_busy", 64'(a_busy), 64'd0);
        check("tmo_done", 64'(done_n[0]), 64'd0);
        send(0, SYNC);
        check("resync_error", 64'(a_err), 64'd0);
        check("resync_busy", 64'(a_busy), 64'd1);
        a_valid = 1'b0;

        frm.delete(); frm.push_back(SYNC);
        for (int e = 1; e <= 3; e++) begin push_word(32'h100 * e); push_word(32'h7 + e); end
        push_word(32'h0000_0444);
        run_load("c5", 1, 0);
        check("c5_error_const", 64'(b_err), 64'd1);

        clear_mon();
        send(0, SYNC); send(0, 8'h10); send(0, 8'h00);
        rst_n = 1'b0;
        a_valid = 1'b0;
        #2;
        check("midrst_flags", {61'd0, a_busy, a_done, a_err}, 64'd0);
        check("midrst_ready", 64'(a_ready), 64'd1);
        @(negedge clk48m) rst_n = 1'b1;
        @(posedge clk48m); #1;
        check("midrst_nwrites", 64'(obs_a.size()), 64'd0);
        frm.delete(); case1_frame();
        run_load("c6", 0, 0);
        check("c6_stalls", 64'(stalls[0]), 64'd2);

        for (int it = 0; it < 30; it++) begin
            sel = 1'($urandom_range(0, 1));
            frm.delete();
            n = int'($urandom_range(0, 3));
            for (int j = 0; j < n; j++) begin
                jb = 8'($urandom);
                if (jb == SYNC) jb = 8'h00;
                frm.push_back(jb);
            end
            frm.push_back(SYNC);
            n = sel ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 5));
            for (int j = 0; j < n; j++) begin
                w = $urandom;
                if (w[26:0] == 27'd0) w = 32'h1;
                push_word(w);
                push_word($urandom);
            end
            w = '0;
            w[31:27] = 5'($urandom_range(0, 31));
            push_word(w);
            run_load($sformatf("rnd%0d", it), sel, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
